// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the two writeback requesters (ALU = A, load = M)
// and the register file.
interface regfile_write_arbiter_if #(
   parameter int unsigned CNT_W = 8
);
   logic             a_valid;
   logic [1:0]       a_addr;
   logic [7:0]       a_data;
   logic             a_ready;
   logic             m_valid;
   logic [1:0]       m_addr;
   logic [7:0]       m_data;
   logic             m_ready;
   logic             sigRegWrite;
   logic [1:0]       writeReg;
   logic [7:0]       writeData;
   logic             last_grant;
   logic [CNT_W-1:0] conflict_cnt;

   // Requester / register-file side
   modport master (
      output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
      input  a_ready, m_ready, sigRegWrite, writeReg, writeData,
             last_grant, conflict_cnt
   );

   // Arbiter side
   modport slave (
      input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
      output a_ready, m_ready, sigRegWrite, writeReg, writeData,
             last_grant, conflict_cnt
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback (A)
// and load writeback (M). Ready is combinational; the write-port drive is
// registered, so a transfer at edge N is written by the register file at N+1.
module regfile_write_arbiter #(
   parameter bit          RR_ENABLE = 1'b1,
   parameter int unsigned CNT_W     = 8
) (
   input logic                    clk,
   input logic                    reset,
   regfile_write_arbiter_if.slave bus
);

   logic             grant_a;
   logic             grant_m;

   logic             sigRegWrite_q, sigRegWrite_d;
   logic [1:0]       writeReg_q,    writeReg_d;
   logic [7:0]       writeData_q,   writeData_d;
   logic             last_grant_q,  last_grant_d;
   logic [CNT_W-1:0] conflict_q,    conflict_d;

   // Grant selection: A wins when alone, under fixed priority, or when M was served last
   always_comb begin
      grant_a = bus.a_valid && (!bus.m_valid || !RR_ENABLE || last_grant_q);
      grant_m = bus.m_valid && !grant_a;
   end

   // Next-state for the write-port drive, grant history and conflict counter
   always_comb begin
      sigRegWrite_d = grant_a || grant_m;
      writeReg_d    = writeReg_q;
      writeData_d   = writeData_q;
      last_grant_d  = last_grant_q;
      conflict_d    = conflict_q;
      if (grant_a) begin
         writeReg_d   = bus.a_addr;
         writeData_d  = bus.a_data;
         last_grant_d = 1'b0;
      end else if (grant_m) begin
         writeReg_d   = bus.m_addr;
         writeData_d  = bus.m_data;
         last_grant_d = 1'b1;
      end
      if (bus.a_valid && bus.m_valid && (conflict_q != '1)) begin
         conflict_d = conflict_q + 1'b1;
      end
   end

   // State registers; reset drops any pending write and favours A next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sigRegWrite_q <= 1'b0;
         writeReg_q    <= '0;
         writeData_q   <= '0;
         last_grant_q  <= 1'b1;
         conflict_q    <= '0;
      end else begin
         sigRegWrite_q <= sigRegWrite_d;
         writeReg_q    <= writeReg_d;
         writeData_q   <= writeData_d;
         last_grant_q  <= last_grant_d;
         conflict_q    <= conflict_d;
      end
   end

   assign bus.a_ready      = grant_a;
   assign bus.m_ready      = grant_m;
   assign bus.sigRegWrite  = sigRegWrite_q;
   assign bus.writeReg     = writeReg_q;
   assign bus.writeData    = writeData_q;
   assign bus.last_grant   = last_grant_q;
   assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: round-robin, fixed-priority and
// narrow-counter instances share clock and reset.
module tb_regfile_write_arbiter;

   logic clk;
   logic reset;

   regfile_write_arbiter_if #(.CNT_W(8)) rr_if ();
   regfile_write_arbiter_if #(.CNT_W(8)) fp_if ();
   regfile_write_arbiter_if #(.CNT_W(2)) sat_if ();

   regfile_write_arbiter #(.RR_ENABLE(1'b1), .CNT_W(8)) dut_rr (
      .clk(clk), .reset(reset), .bus(rr_if.slave));
   regfile_write_arbiter #(.RR_ENABLE(1'b0), .CNT_W(8)) dut_fp (
      .clk(clk), .reset(reset), .bus(fp_if.slave));
   regfile_write_arbiter #(.RR_ENABLE(1'b1), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .bus(sat_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file downstream of the round-robin instance
   logic [7:0] rf [4];
   always @(posedge clk) begin
      if (rr_if.sigRegWrite === 1'b1) rf[rr_if.writeReg] <= rr_if.writeData;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      rr_if.a_valid = 0;  rr_if.a_addr = 0;  rr_if.a_data = 0;
      rr_if.m_valid = 0;  rr_if.m_addr = 0;  rr_if.m_data = 0;
      fp_if.a_valid = 0;  fp_if.a_addr = 0;  fp_if.a_data = 0;
      fp_if.m_valid = 0;  fp_if.m_addr = 0;  fp_if.m_data = 0;
      sat_if.a_valid = 0; sat_if.a_addr = 0; sat_if.a_data = 0;
      sat_if.m_valid = 0; sat_if.m_addr = 0; sat_if.m_data = 0;

      // Reset asserted mid-cycle, checked before the next edge
      #7 reset = 1'b1;
      #1;
      check("rst_we",    rr_if.sigRegWrite,  1'b0);
      check("rst_reg",   rr_if.writeReg,     2'd0);
      check("rst_data",  rr_if.writeData,    8'h00);
      check("rst_cnt",   rr_if.conflict_cnt, 8'd0);
      check("rst_last",  rr_if.last_grant,   1'b1);
      check("rst_satcnt", sat_if.conflict_cnt, 2'd0);
      #4 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_we", rr_if.sigRegWrite, 1'b0);
      end

      // Round-robin contention: A first (last_grant=1), then M, then A again
      rr_if.a_valid = 1; rr_if.a_addr = 2'd1; rr_if.a_data = 8'h11;
      rr_if.m_valid = 1; rr_if.m_addr = 2'd3; rr_if.m_data = 8'h33;
      #1;
      check("rr1_a_rdy", rr_if.a_ready, 1'b1);
      check("rr1_m_rdy", rr_if.m_ready, 1'b0);
      step();
      rr_if.a_addr = 2'd2; rr_if.a_data = 8'h22;
      check("rr1_we",   rr_if.sigRegWrite,  1'b1);
      check("rr1_reg",  rr_if.writeReg,     2'd1);
      check("rr1_data", rr_if.writeData,    8'h11);
      check("rr1_cnt",  rr_if.conflict_cnt, 8'd1);
      check("rr1_last", rr_if.last_grant,   1'b0);
      #1;
      check("rr2_m_rdy", rr_if.m_ready, 1'b1);
      check("rr2_a_rdy", rr_if.a_ready, 1'b0);
      step();
      rr_if.m_valid = 0;
      check("rr2_we",   rr_if.sigRegWrite,  1'b1);
      check("rr2_reg",  rr_if.writeReg,     2'd3);
      check("rr2_data", rr_if.writeData,    8'h33);
      check("rr2_cnt",  rr_if.conflict_cnt, 8'd2);
      check("rr2_last", rr_if.last_grant,   1'b1);
      #1;
      check("rr3_a_rdy", rr_if.a_ready, 1'b1);
      step();
      rr_if.a_valid = 0;
      check("rr3_reg",  rr_if.writeReg,     2'd2);
      check("rr3_data", rr_if.writeData,    8'h22);
      check("rr3_cnt",  rr_if.conflict_cnt, 8'd2);

      // Single writer A
      rr_if.a_valid = 1; rr_if.a_addr = 2'd2; rr_if.a_data = 8'h5A;
      #1;
      check("sw_a_rdy", rr_if.a_ready, 1'b1);
      check("sw_m_rdy", rr_if.m_ready, 1'b0);
      step();
      rr_if.a_valid = 0;
      check("sw_we",   rr_if.sigRegWrite, 1'b1);
      check("sw_reg",  rr_if.writeReg,    2'd2);
      check("sw_data", rr_if.writeData,   8'h5A);
      step();
      check("sw_idle_we",   rr_if.sigRegWrite, 1'b0);
      check("sw_hold_reg",  rr_if.writeReg,    2'd2);
      check("sw_hold_data", rr_if.writeData,   8'h5A);

      // Same address with last_grant=0: M then A, reg0 ends at AA
      rr_if.a_valid = 1; rr_if.a_addr = 2'd0; rr_if.a_data = 8'hAA;
      rr_if.m_valid = 1; rr_if.m_addr = 2'd0; rr_if.m_data = 8'hBB;
      #1;
      check("sa_m_rdy", rr_if.m_ready, 1'b1);
      check("sa_a_rdy", rr_if.a_ready, 1'b0);
      step();
      rr_if.m_valid = 0;
      check("sa1_reg",  rr_if.writeReg,     2'd0);
      check("sa1_data", rr_if.writeData,    8'hBB);
      check("sa1_cnt",  rr_if.conflict_cnt, 8'd3);
      #1;
      check("sa2_a_rdy", rr_if.a_ready, 1'b1);
      step();
      rr_if.a_valid = 0;
      check("sa2_data", rr_if.writeData, 8'hAA);
      step();
      check("sa_rf0", rf[0], 8'hAA);
      check("sa_idle_we", rr_if.sigRegWrite, 1'b0);

      // Fixed priority: A re-presents each cycle, M waits
      fp_if.a_valid = 1; fp_if.a_addr = 2'd2;
      fp_if.m_valid = 1; fp_if.m_addr = 2'd1; fp_if.m_data = 8'h77;
      for (int i = 0; i < 3; i++) begin
         fp_if.a_data = 8'hC0 + 8'(i);
         #1;
         check("fp_a_rdy", fp_if.a_ready, 1'b1);
         check("fp_m_rdy", fp_if.m_ready, 1'b0);
         step();
         check("fp_data", fp_if.writeData,    32'hC0 + 32'(i));
         check("fp_cnt",  fp_if.conflict_cnt, 32'(i + 1));
      end
      fp_if.a_valid = 0;
      #1;
      check("fp_m_rdy_alone", fp_if.m_ready, 1'b1);
      step();
      fp_if.m_valid = 0;
      check("fp_m_reg",  fp_if.writeReg,     2'd1);
      check("fp_m_data", fp_if.writeData,    8'h77);
      check("fp_m_cnt",  fp_if.conflict_cnt, 8'd3);

      // Saturating 2-bit counter, then reset while a write is pending
      sat_if.a_valid = 1; sat_if.a_addr = 2'd1; sat_if.a_data = 8'hA1;
      sat_if.m_valid = 1; sat_if.m_addr = 2'd2; sat_if.m_data = 8'hB2;
      for (int i = 0; i < 6; i++) begin
         step();
         check("sat_cnt", sat_if.conflict_cnt, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      end
      check("sat_we_pending", sat_if.sigRegWrite, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_we",   sat_if.sigRegWrite,  1'b0);
      check("mid_rst_cnt",  sat_if.conflict_cnt, 2'd0);
      check("mid_rst_last", sat_if.last_grant,   1'b1);
      check("mid_rst_data", sat_if.writeData,    8'h00);
      #2 reset = 1'b0;
      #1;
      check("post_rst_a_rdy", sat_if.a_ready, 1'b1);
      check("post_rst_m_rdy", sat_if.m_ready, 1'b0);
      step();
      sat_if.a_valid = 0; sat_if.m_valid = 0;
      check("post_rst_data", sat_if.writeData,  8'hA1);
      check("post_rst_last", sat_if.last_grant, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
